// File: rtl/coin_acceptor_if.sv
// Coin delivery handshake between the acceptor and the vending controller.
//   coin_valid : head of the coin queue is valid
//   coin_ready : controller accepts the head coin this cycle
//   coin_code  : 01=5c, 10=10c, 11=25c, 00 when coin_valid is low
// master = coin_acceptor side, slave = controller side.
interface coin_acceptor_if;
  logic       coin_valid;
  logic       coin_ready;
  logic [1:0] coin_code;

  modport master (
    output coin_valid,
    output coin_code,
    input  coin_ready
  );

  modport slave (
    input  coin_valid,
    input  coin_code,
    output coin_ready
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the raw optical sensor,
// measures debounced pulse width, classifies 5c/10c/25c or rejects, detects
// jams, queues accepted coins and delivers them over a valid/ready handshake.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   coin_sense  : raw asynchronous sensor line, high while a coin passes
//   clr_total   : synchronous clear of total_cents
//   coin        : delivery handshake (master side)
//   reject      : one-cycle pulse, coin returned to user
//   jam         : high while a jam is in progress
//   fifo_count  : number of queued coins
//   total_cents : saturating sum of delivered coin values
module coin_acceptor #(
  parameter int unsigned DEB_CYC     = 4,
  parameter int unsigned NICKEL_MIN  = 8,
  parameter int unsigned NICKEL_MAX  = 15,
  parameter int unsigned DIME_MIN    = 16,
  parameter int unsigned DIME_MAX    = 31,
  parameter int unsigned QUARTER_MIN = 32,
  parameter int unsigned QUARTER_MAX = 63,
  parameter int unsigned JAM_CYC     = 255,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            coin_sense,
  input  logic                            clr_total,
  coin_acceptor_if.master                 coin,
  output logic                            reject,
  output logic                            jam,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                     total_cents
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned DebW = $clog2(DEB_CYC + 1);
  localparam logic [PtrW:0] FullCnt = FIFO_DEPTH[PtrW:0];

  typedef enum logic [1:0] {StIdle, StMeasure, StClassify, StJam} state_e;

  // Input path
  logic [1:0]      sync_q;
  logic            deb_q;
  logic [DebW-1:0] deb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b00;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], coin_sense};
      if (sync_q[1] != deb_q) begin
        // Level flips on the DEB_CYC-th consecutive disagreeing cycle.
        if (deb_cnt_q == DebW'(DEB_CYC - 1)) begin
          deb_q     <= sync_q[1];
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // FIFO state and handshake
  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q;
  logic            pop, push, can_accept;

  assign coin.coin_valid = (count_q != '0);
  assign coin.coin_code  = coin.coin_valid ? mem_q[rd_ptr_q] : 2'b00;
  assign pop             = coin.coin_valid && coin.coin_ready;
  assign can_accept      = (count_q != FullCnt) || pop;
  assign fifo_count      = count_q;

  // Classification of the captured width
  state_e     state_q;
  logic [7:0] width_q;
  logic [1:0] class_code;

  always_comb begin
    class_code = 2'b00;
    if (width_q >= 8'(NICKEL_MIN) && width_q <= 8'(NICKEL_MAX)) begin
      class_code = 2'b01;
    end else if (width_q >= 8'(DIME_MIN) && width_q <= 8'(DIME_MAX)) begin
      class_code = 2'b10;
    end else if (width_q >= 8'(QUARTER_MIN) && width_q <= 8'(QUARTER_MAX)) begin
      class_code = 2'b11;
    end
  end

  assign push = (state_q == StClassify) && (class_code != 2'b00) && can_accept;

  // Measurement FSM; reject and jam are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      width_q <= '0;
      reject  <= 1'b0;
      jam     <= 1'b0;
    end else begin
      reject <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // IDLE is only entered with the debounced level low, so level == edge.
          if (deb_q) begin
            state_q <= StMeasure;
            width_q <= 8'd1;
          end
        end
        StMeasure: begin
          if (!deb_q) begin
            state_q <= StClassify;
          end else if (width_q == 8'(JAM_CYC - 1)) begin
            width_q <= width_q + 8'd1;
            state_q <= StJam;
            jam     <= 1'b1;
          end else begin
            width_q <= width_q + 8'd1;
          end
        end
        StClassify: begin
          if (!push) begin
            reject <= 1'b1;
          end
          state_q <= StIdle;
        end
        StJam: begin
          if (!deb_q) begin
            state_q <= StIdle;
            jam     <= 1'b0;
            reject  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= class_code;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Running total
  logic [15:0] pop_val;
  logic [16:0] sum;

  always_comb begin
    pop_val = 16'd0;
    case (coin.coin_code)
      2'b01:   pop_val = 16'd5;
      2'b10:   pop_val = 16'd10;
      2'b11:   pop_val = 16'd25;
      default: pop_val = 16'd0;
    endcase
    sum = {1'b0, total_cents} + {1'b0, pop_val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_cents <= 16'd0;
    end else if (clr_total) begin
      total_cents <= pop ? pop_val : 16'd0;
    end else if (pop) begin
      total_cents <= sum[16] ? 16'hffff : sum[15:0];
    end
  end

endmodule
